// File: rtl/mpls_label_bram_arbiter.sv
// mpls_label_bram_arbiter
// Arbitrates one host write port and NUM_RD read ports onto a single-port
// label-table BRAM. After reset the whole table is cleared (INIT), then one
// BRAM operation per cycle is granted (RUN): writes win, except that once
// WR_STREAK_MAX consecutive write grants have been made while a read waits,
// a read is forced through. Reads are served round-robin.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   wr_req/addr/data      host write request (held until wr_ack)
//   wr_ack                1-cycle write-accepted pulse
//   rd_req[NUM_RD]        per-port read request (held until rd_ack)
//   rd_addr               packed per-port read address, port i at [i*ADDR_W +: ADDR_W]
//   rd_ack[NUM_RD]        1-cycle read-accepted pulse
//   rd_valid[NUM_RD]      1-cycle pulse, rd_data belongs to that port (2 cycles after rd_ack)
//   rd_data               shared read data, holds when rd_valid is zero
//   bram_we/addr/din      registered BRAM controls
//   bram_dout             BRAM output, one cycle after bram_addr
//   init_done             high once the table clear has completed
module mpls_label_bram_arbiter #(
    parameter int unsigned NUM_RD        = 4,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 48,
    parameter int unsigned WR_STREAK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [DATA_W-1:0]        bram_din,
    input  logic [DATA_W-1:0]        bram_dout,
    output logic                     init_done
);

    localparam int unsigned PTR_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned STRK_W = $clog2(WR_STREAK_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [STRK_W-1:0]   streak;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_RD-1:0]   rd_pend;     // read whose BRAM access happens this edge

    logic                wr_elig_c;
    logic [NUM_RD-1:0]   rd_elig_c;
    logic                rd_any_c;
    logic                streak_max_c;
    logic                write_wins_c;
    logic                do_wr_c;
    logic                do_rd_c;
    logic                idle_c;
    logic                found_c;
    int unsigned         idx_c;
    logic [PTR_W-1:0]    rd_sel_c;
    logic [ADDR_W-1:0]   rd_sel_addr_c;

    // Grant decision. A write that owns the slot but is still in its ack
    // cycle leaves a bubble; the streak is kept so a waiting read gets in
    // once the limit is reached.
    always_comb begin
        wr_elig_c    = wr_req && !wr_ack;
        rd_elig_c    = rd_req & ~rd_ack;
        rd_any_c     = |rd_elig_c;
        streak_max_c = (streak == STRK_W'(WR_STREAK_MAX));
        write_wins_c = wr_req && !(streak_max_c && rd_any_c);
        do_wr_c      = write_wins_c && wr_elig_c;
        do_rd_c      = !write_wins_c && rd_any_c;
        idle_c       = !wr_elig_c && !rd_any_c;
    end

    // Round-robin pick, searching from the port after the last grant.
    always_comb begin
        found_c  = 1'b0;
        idx_c    = 0;
        rd_sel_c = rr_ptr;
        for (int unsigned off = 1; off <= NUM_RD; off++) begin
            idx_c = (32'(rr_ptr) + off) % NUM_RD;
            if (!found_c && rd_elig_c[PTR_W'(idx_c)]) begin
                found_c  = 1'b1;
                rd_sel_c = PTR_W'(idx_c);
            end
        end
        rd_sel_addr_c = rd_addr[32'(rd_sel_c)*ADDR_W +: ADDR_W];
    end

    // State, BRAM controls, acks and read-return pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= '0;
            rd_pend   <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            streak    <= '0;
            rr_ptr    <= PTR_W'(NUM_RD - 1);
        end else begin
            wr_ack   <= 1'b0;
            rd_ack   <= '0;
            rd_pend  <= rd_ack;
            rd_valid <= rd_pend;
            if (|rd_pend) begin
                rd_data <= bram_dout;
            end
            case (state)
                ST_INIT: begin
                    bram_we   <= 1'b1;
                    bram_din  <= '0;
                    bram_addr <= clr_cnt;
                    clr_cnt   <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    bram_we <= 1'b0;
                    if (do_wr_c) begin
                        bram_we   <= 1'b1;
                        bram_addr <= wr_addr;
                        bram_din  <= wr_data;
                        wr_ack    <= 1'b1;
                        if (!streak_max_c) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (do_rd_c) begin
                        bram_addr        <= rd_sel_addr_c;
                        rd_ack[rd_sel_c] <= 1'b1;
                        rr_ptr           <= rd_sel_c;
                        streak           <= '0;
                    end else if (idle_c) begin
                        streak <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mpls_label_bram_arbiter.sv
// Directed testbench for mpls_label_bram_arbiter with a behavioural
// single-port BRAM (one cycle read latency, read-before-write).
module tb_mpls_label_bram_arbiter;

    localparam int unsigned NUM_RD = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 48;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_req;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ack;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_ack;
    logic [NUM_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     bram_we;
    logic [ADDR_W-1:0]        bram_addr;
    logic [DATA_W-1:0]        bram_din;
    logic [DATA_W-1:0]        bram_dout;
    logic                     init_done;

    logic [DATA_W-1:0] mem [256];

    int vecs = 0;
    int errs = 0;

    mpls_label_bram_arbiter #(
        .NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_STREAK_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs the 256-cycle clear sweep that follows reset release.
    task automatic init_sweep(input string tag);
        int bad_ack  = 0;
        int bad_bram = 0;
        int bad_v    = 0;
        int early    = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (wr_ack || rd_ack != 0) bad_ack++;
            if (!bram_we || bram_addr != 8'(i) || bram_din != 0) bad_bram++;
            if (rd_valid != 0) bad_v++;
            if (i < 255 && init_done) early++;
        end
        chk({tag, "_no_ack"},     64'(bad_ack),  64'd0);
        chk({tag, "_sweep"},      64'(bad_bram), 64'd0);
        chk({tag, "_no_valid"},   64'(bad_v),    64'd0);
        chk({tag, "_done_early"}, 64'(early),    64'd0);
        chk({tag, "_init_done"},  64'(init_done), 64'd1);
    endtask

    function automatic logic [DATA_W-1:0] dk(input int k);
        return 48'h1111_0000_00A0 + 48'(k);
    endfunction

    initial begin
        logic [8:0] ew;
        logic [8:0] er;
        int gp [12];
        logic [DATA_W-1:0] d30;

        reset   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = '0;
        rd_addr = '0;
        d30     = 48'hABCD_EF01_2345;

        // Reset state
        repeat (3) step();
        chk("rst_init_done", 64'(init_done), 0);
        chk("rst_acks",      64'({wr_ack, rd_ack}), 0);
        chk("rst_valid",     64'(rd_valid), 0);
        chk("rst_bram",      64'({bram_we, bram_addr}), 0);
        chk("rst_din_data",  64'(bram_din | rd_data), 0);

        // Read held across INIT: no ack until the sweep ends, then data 0
        rd_req[0]   = 1'b1;
        rd_addr[7:0] = 8'h05;
        reset       = 1'b1;
        init_sweep("init");
        step();
        chk("first_rd_ack",  64'(rd_ack), 64'h1);
        chk("first_rd_addr", 64'(bram_addr), 64'h05);
        chk("first_rd_we",   64'(bram_we), 0);
        rd_req = '0;
        step();
        chk("first_rd_v_early", 64'(rd_valid), 0);
        step();
        chk("first_rd_valid", 64'(rd_valid), 64'h1);
        chk("first_rd_data",  64'(rd_data), 0);

        // Write then read-after-write on port 2
        wr_req  = 1'b1;
        wr_addr = 8'h05;
        wr_data = 48'h0000_1234_5678;
        step();
        chk("raw_wr_ack", 64'(wr_ack), 1);
        chk("raw_bram",   64'({bram_we, bram_addr}), 64'h105);
        chk("raw_din",    64'(bram_din), 64'h0000_1234_5678);
        wr_req = 1'b0;
        rd_req = 4'b0100;
        rd_addr[2*8 +: 8] = 8'h05;
        step();
        chk("raw_rd_ack", 64'(rd_ack), 64'h4);
        rd_req = '0;
        step();
        step();
        chk("raw_valid", 64'(rd_valid), 64'h4);
        chk("raw_data",  64'(rd_data), 64'h0000_1234_5678);

        // Load 0x20..0x23 with distinct entries
        for (int k = 0; k < 4; k++) begin
            wr_req  = 1'b1;
            wr_addr = 8'h20 + 8'(k);
            wr_data = dk(k);
            step();
            chk("load_wr_ack", 64'(wr_ack), 1);
            wr_req = 1'b0;
            step();
        end

        // All four reads held: rotate one per cycle from the port after 2
        for (int p = 0; p < 4; p++) rd_addr[p*8 +: 8] = 8'h20 + 8'(p);
        rd_req = 4'hF;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i < 10) begin
                gp[i] = (3 + i) % 4;
                chk("rr_ack", 64'(rd_ack), 64'(1 << gp[i]));
            end else begin
                chk("rr_ack_idle", 64'(rd_ack), 0);
            end
            if (i >= 2) begin
                chk("rr_valid", 64'(rd_valid), 64'(1 << gp[i-2]));
                chk("rr_data",  64'(rd_data), 64'(dk(gp[i-2])));
            end
            if (i == 9) rd_req = '0;
        end

        // Write streak: held write vs held read on port 1
        ew = 9'b1_0101_0101;
        er = 9'b0_1000_0000;
        wr_req  = 1'b1;
        wr_addr = 8'h30;
        wr_data = d30;
        rd_addr[1*8 +: 8] = 8'h21;
        rd_req  = 4'b0010;
        for (int e = 0; e < 9; e++) begin
            step();
            chk("streak_wr_ack", 64'(wr_ack), 64'(ew[e]));
            chk("streak_rd_ack", 64'(rd_ack[1]), 64'(er[e]));
            if (e == 7) rd_req = '0;
            if (e == 8) wr_req = 1'b0;
        end
        step();
        chk("streak_valid", 64'(rd_valid), 64'h2);
        chk("streak_data",  64'(rd_data), 64'(dk(1)));

        // Simultaneous write and read with streak 0: write first
        rd_addr[7:0] = 8'h30;
        rd_req  = 4'b0001;
        wr_req  = 1'b1;
        wr_addr = 8'h31;
        wr_data = 48'h0000_0000_0777;
        step();
        chk("sim_wr_first", 64'({wr_ack, rd_ack}), 64'h10);
        wr_req = 1'b0;
        step();
        chk("sim_rd_next", 64'({wr_ack, rd_ack}), 64'h01);
        rd_req = '0;
        step();
        step();
        chk("sim_valid", 64'(rd_valid), 64'h1);
        chk("sim_data",  64'(rd_data), 64'(d30));

        // Reset one cycle after rd_ack[3]: in-flight read dropped, INIT repeats
        rd_addr[3*8 +: 8] = 8'h23;
        rd_req = 4'b1000;
        step();
        chk("mid_rd_ack", 64'(rd_ack), 64'h8);
        reset  = 1'b0;
        rd_req = '0;
        step();
        chk("mid_rst_state", 64'({init_done, wr_ack, rd_ack, rd_valid}), 0);
        chk("mid_rst_bram",  64'({bram_we, bram_addr}), 0);
        chk("mid_rst_data",  64'(rd_data), 0);
        reset = 1'b1;
        init_sweep("reinit");

        // Table cleared by the second sweep
        rd_addr[1*8 +: 8] = 8'h21;
        rd_req = 4'b0010;
        step();
        chk("clr_rd_ack", 64'(rd_ack), 64'h2);
        rd_req = '0;
        step();
        step();
        chk("clr_valid", 64'(rd_valid), 64'h2);
        chk("clr_data",  64'(rd_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mpls_label_bram_arbiter.md
MPLS_LABEL_BRAM_ARBITER -- requirements
Module: mpls_label_bram_arbiter

Interface
REQ-001 Parameter NUM_RD, default 4, number of read requester ports (2..8).
REQ-002 Parameter ADDR_W, default 8, table address width.
REQ-003 Parameter DATA_W, default 48, table entry width.
REQ-004 Parameter WR_STREAK_MAX, default 4, consecutive write grants allowed while any read is pending.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 wr_req  input  1  host write request, held until wr_ack.
REQ-008 wr_addr / wr_data  input  ADDR_W / DATA_W  write address and entry.
REQ-009 wr_ack  output  1  one-cycle pulse: write accepted.
REQ-010 rd_req  input  NUM_RD  per-port read request, held until rd_ack.
REQ-011 rd_addr  input  NUM_RD*ADDR_W  per-port read address; port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 rd_ack  output  NUM_RD  one-cycle pulse: read accepted.
REQ-013 rd_valid  output  NUM_RD  one-cycle pulse: rd_data belongs to that port.
REQ-014 rd_data  output  DATA_W  shared read data, valid only while a rd_valid bit is high.
REQ-015 bram_we / bram_addr / bram_din  output  1 / ADDR_W / DATA_W  single-port BRAM controls, all registered.
REQ-016 bram_dout  input  DATA_W  BRAM output; one cycle read latency after bram_addr.
REQ-017 init_done  output  1  high once table clear completes.

Function
REQ-018 FSM states: INIT (clear table), RUN (arbitrate); there is no other state.
REQ-019 INIT: each cycle bram_we=1, bram_din=0, bram_addr = clear counter, counter 0..2^ADDR_W-1; on the cycle the last address is written, move to RUN and set init_done=1.
REQ-020 INIT: no wr_ack or rd_ack is issued; requests stay pending.
REQ-021 RUN: at most one BRAM operation per cycle; a grant registers bram_addr/bram_we/bram_din and the matching ack in the same edge.
REQ-022 Priority: write wins over reads unless the write-streak counter equals WR_STREAK_MAX and at least one read is eligible; in that case a read is granted and the streak resets to 0.
REQ-023 Write-streak counter increments on each write grant, resets to 0 on any read grant or idle cycle; it saturates at WR_STREAK_MAX.
REQ-024 Reads: round-robin among eligible ports, starting from the port after the last granted read port; the pointer updates only on a read grant.
REQ-025 A port (or the write port) whose ack is high in the current cycle is not eligible that cycle, so a held request is never double-granted.
REQ-026 Idle cycle (no eligible request): bram_we=0, bram_addr holds its last value.
REQ-027 Read latency: rd_valid[i] and rd_data assert exactly 2 cycles after rd_ack[i] (ack edge, BRAM edge, output register edge).
REQ-028 Throughput: one grant per cycle sustained across ports; a single port is limited to one grant per 2 cycles.
REQ-029 A read granted in the cycle after a write to the same address returns the new data.
REQ-030 rd_valid is one-hot or zero; rd_data holds its last value when rd_valid=0.
REQ-031 Simultaneous wr_req and all rd_req in the same cycle are resolved per REQ-022/REQ-024 with no lost request.

Reset
REQ-032 While reset=0 at an edge: state=INIT, clear counter=0, init_done=0, all acks/rd_valid=0, bram_we=0, bram_addr=0, bram_din=0, rd_data=0, streak=0, RR pointer = port NUM_RD-1 (so port 0 is first).
REQ-033 Reset asserted mid-operation discards in-flight reads: no rd_valid is produced for them after reset release.
REQ-034 After reset release the full INIT sweep is repeated (2^ADDR_W cycles) before any ack.

Verification
REQ-035 Release reset, hold rd_req[0]=1, addr 0x05 -> no ack for 256 cycles, init_done rises, rd_ack[0] pulses next, rd_valid[0] 2 cycles later with rd_data=0.
REQ-036 Write 0x0000_1234_5678 at 0x05, then read port 2 addr 0x05 in the following cycle -> rd_valid[2] with rd_data=0x000012345678.
REQ-037 All 4 rd_req held continuously -> grants 0,1,2,3,0,... one per cycle, each rd_valid exactly 2 cycles after its ack.
REQ-038 wr_req held continuously, rd_req[1] held -> 4 wr_acks, then rd_ack[1], then writes resume.
REQ-039 Drive reset=0 one cycle after rd_ack[3] -> no rd_valid[3] appears; INIT repeats; init_done=0 for 256 cycles.
REQ-040 wr_req and rd_req[0] held in the same cycle with streak=0 -> wr_ack first, rd_ack[0] in the next cycle.
